// File: rtl/daq_frame_reader_if.sv
// rtl/daq_frame_reader_if.sv - FIFO read port, host byte stream and status bundle for daq_frame_reader
interface daq_frame_reader_if;
    logic       en_i;
    logic       fifo_empty_i;
    logic [7:0] fifo_data_i;
    logic       fifo_rdreq_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       busy_o;
    logic       frame_done_o;
    logic [7:0] seq_o;

    modport master (
        input  en_i,
        input  fifo_empty_i,
        input  fifo_data_i,
        output fifo_rdreq_o,
        output tx_data_o,
        output tx_valid_o,
        input  tx_ready_i,
        output busy_o,
        output frame_done_o,
        output seq_o
    );

    modport slave (
        output en_i,
        output fifo_empty_i,
        output fifo_data_i,
        input  fifo_rdreq_o,
        input  tx_data_o,
        input  tx_valid_o,
        output tx_ready_i,
        input  busy_o,
        input  frame_done_o,
        input  seq_o
    );
endinterface

// File: rtl/daq_frame_reader.sv
// rtl/daq_frame_reader.sv - drains the ADC sample FIFO into framed bytes; DAQ_FRAME_CHECKSUM_EN adds the checksum trailer
module daq_frame_reader #(
    parameter int         PAYLOAD_BYTES = 16,
    parameter logic [7:0] HEADER_BYTE   = 8'hA5
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    daq_frame_reader_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_SEQ    = 3'd2,
        S_FETCH  = 3'd3,
        S_LATCH  = 3'd4,
        S_SEND   = 3'd5,
        S_CSUM   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);

    state_t     r_state,      w_state_nx;
    logic [7:0] r_seq,        w_seq_nx;
    logic [7:0] r_byte_cnt,   w_byte_cnt_nx;
    logic [7:0] r_tx_data,    w_tx_data_nx;
    logic       r_tx_valid,   w_tx_valid_nx;
    logic       r_rdreq,      w_rdreq_nx;
    logic       r_frame_done, w_frame_done_nx;
    logic       r_busy,       w_busy_nx;
    logic       w_accept;
`ifdef DAQ_FRAME_CHECKSUM_EN
    logic [7:0] r_sum,        w_sum_nx;
`endif

    assign w_accept = r_tx_valid && bus.tx_ready_i;

    // Every output is a register loaded with the value belonging to the next state.
    // The read request is issued on entry to FETCH so that the non-show-ahead data
    // is on fifo_data_i during LATCH; this is safe because only this block pops the FIFO.
    always_comb begin
        w_state_nx      = r_state;
        w_seq_nx        = r_seq;
        w_byte_cnt_nx   = r_byte_cnt;
        w_tx_data_nx    = r_tx_data;
        w_tx_valid_nx   = r_tx_valid;
        w_rdreq_nx      = 1'b0;
        w_frame_done_nx = 1'b0;
`ifdef DAQ_FRAME_CHECKSUM_EN
        w_sum_nx        = r_sum;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.en_i && !bus.fifo_empty_i) begin
                    w_state_nx    = S_HEADER;
                    w_tx_valid_nx = 1'b1;
                    w_tx_data_nx  = HEADER_BYTE;
                    w_byte_cnt_nx = 8'd0;
`ifdef DAQ_FRAME_CHECKSUM_EN
                    w_sum_nx      = 8'd0;
`endif
                end
            end
            S_HEADER: begin
                if (w_accept) begin
                    w_state_nx   = S_SEQ;
                    w_tx_data_nx = r_seq;
                end
            end
            S_SEQ: begin
                if (w_accept) begin
                    w_state_nx    = S_FETCH;
                    w_tx_valid_nx = 1'b0;
                    w_rdreq_nx    = !bus.fifo_empty_i;
`ifdef DAQ_FRAME_CHECKSUM_EN
                    w_sum_nx      = r_seq;
`endif
                end
            end
            S_FETCH: begin
                // A request already in flight means the data lands next cycle; otherwise wait for data.
                if (r_rdreq) begin
                    w_state_nx = S_LATCH;
                end else if (!bus.fifo_empty_i) begin
                    w_rdreq_nx = 1'b1;
                end
            end
            S_LATCH: begin
                w_state_nx    = S_SEND;
                w_tx_valid_nx = 1'b1;
                w_tx_data_nx  = bus.fifo_data_i;
`ifdef DAQ_FRAME_CHECKSUM_EN
                w_sum_nx      = r_sum + bus.fifo_data_i;
`endif
            end
            S_SEND: begin
                if (w_accept) begin
                    w_tx_valid_nx = 1'b0;
                    if (r_byte_cnt == LAST_IDX) begin
`ifdef DAQ_FRAME_CHECKSUM_EN
                        w_state_nx    = S_CSUM;
                        w_tx_valid_nx = 1'b1;
                        w_tx_data_nx  = r_sum;
`else
                        w_state_nx      = S_DONE;
                        w_frame_done_nx = 1'b1;
`endif
                    end else begin
                        w_state_nx    = S_FETCH;
                        w_byte_cnt_nx = r_byte_cnt + 8'd1;
                        w_rdreq_nx    = !bus.fifo_empty_i;
                    end
                end
            end
`ifdef DAQ_FRAME_CHECKSUM_EN
            S_CSUM: begin
                if (w_accept) begin
                    w_state_nx      = S_DONE;
                    w_tx_valid_nx   = 1'b0;
                    w_frame_done_nx = 1'b1;
                end
            end
`endif
            S_DONE: begin
                w_state_nx = S_IDLE;
                w_seq_nx   = r_seq + 8'd1;
            end
            default: begin
                w_state_nx    = S_IDLE;
                w_tx_valid_nx = 1'b0;
            end
        endcase
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state      <= S_IDLE;
            r_seq        <= 8'd0;
            r_byte_cnt   <= 8'd0;
            r_tx_data    <= 8'd0;
            r_tx_valid   <= 1'b0;
            r_rdreq      <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_seq        <= w_seq_nx;
            r_byte_cnt   <= w_byte_cnt_nx;
            r_tx_data    <= w_tx_data_nx;
            r_tx_valid   <= w_tx_valid_nx;
            r_rdreq      <= w_rdreq_nx;
            r_frame_done <= w_frame_done_nx;
            r_busy       <= w_busy_nx;
        end
    end

`ifdef DAQ_FRAME_CHECKSUM_EN
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_sum <= 8'd0;
        end else begin
            r_sum <= w_sum_nx;
        end
    end
`endif

    assign bus.fifo_rdreq_o = r_rdreq;
    assign bus.tx_data_o    = r_tx_data;
    assign bus.tx_valid_o   = r_tx_valid;
    assign bus.busy_o       = r_busy;
    assign bus.frame_done_o = r_frame_done;
    assign bus.seq_o        = r_seq;

endmodule
